// File: rtl/tc_pl_spi_master.sv
// rtl/tc_pl_spi_master.sv - mode-0 MSB-first SPI master engine with chip-select vector
// Optional build macro: TC_SPI_LATE_SAMPLE_EN (sample MISO on the SCLK falling transition)
module tc_pl_spi_master #(
   parameter int AGP0_25 = 8,
   parameter int DW      = 32,
   parameter int DIV     = 4,
   parameter int GAP_CYC = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [AGP0_25-1:0] cmd_sel,
   input  logic [5:0]         cmd_len,
   input  logic [DW-1:0]      cmd_wdata,
   output logic               rsp_valid,
   output logic [DW-1:0]      rsp_rdata,
   output logic               busy,
   output logic [AGP0_25-1:0] chip_sel,
   output logic               spi_CSN,
   output logic               spi_SCLK,
   output logic               spi_MOSI,
   input  logic               spi_MISO
);

   localparam int HW = $clog2(DIV + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [5:0]    LEN_MAX = 6'(DW - 1);
   localparam logic [HW-1:0] HALF    = HW'(DIV - 1);
   localparam logic [GW-1:0] GAP_LD  = GW'(GAP_CYC - 1);

`ifdef TC_SPI_LATE_SAMPLE_EN
   localparam bit LATE = 1'b1;
`else
   localparam bit LATE = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      SHIFT = 3'd2,
      LAG   = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t              state, state_nx;
   logic [HW-1:0]       hcnt, hcnt_nx;
   logic [GW-1:0]       gcnt, gcnt_nx;
   logic [5:0]          bcnt, bcnt_nx;
   logic [DW-1:0]       tx, tx_nx;
   logic [DW-1:0]       rx, rx_nx;
   logic [AGP0_25-1:0]  sel_nx;
   logic                csn_nx, sclk_nx, mosi_nx;
   logic                rsp_valid_nx, ready_nx, busy_nx;
   logic [DW-1:0]       rdata_nx;

   logic [5:0]          n_m1;
   logic [6:0]          shamt;
   logic [DW-1:0]       tx_load, tx_shl, rx_shl;

   // Register every output and the engine state; reset forces the idle picture at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         hcnt      <= '0;
         gcnt      <= '0;
         bcnt      <= '0;
         tx        <= '0;
         rx        <= '0;
         chip_sel  <= '0;
         spi_CSN   <= 1'b1;
         spi_SCLK  <= 1'b0;
         spi_MOSI  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         hcnt      <= hcnt_nx;
         gcnt      <= gcnt_nx;
         bcnt      <= bcnt_nx;
         tx        <= tx_nx;
         rx        <= rx_nx;
         chip_sel  <= sel_nx;
         spi_CSN   <= csn_nx;
         spi_SCLK  <= sclk_nx;
         spi_MOSI  <= mosi_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_rdata <= rdata_nx;
         cmd_ready <= ready_nx;
         busy      <= busy_nx;
      end
   end

   // Frame sequencing: next state plus next value of every registered output.
   always_comb begin
      state_nx     = state;
      hcnt_nx      = hcnt;
      gcnt_nx      = gcnt;
      bcnt_nx      = bcnt;
      tx_nx        = tx;
      rx_nx        = rx;
      sel_nx       = chip_sel;
      csn_nx       = spi_CSN;
      sclk_nx      = spi_SCLK;
      mosi_nx      = spi_MOSI;
      rsp_valid_nx = 1'b0;
      rdata_nx     = rsp_rdata;
      ready_nx     = cmd_ready;
      busy_nx      = busy;

      // Clamp the frame to DW bits and left-align the transmit word so bit N-1 sits at the MSB.
      n_m1    = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
      shamt   = 7'(DW - 1) - {1'b0, n_m1};
      tx_load = cmd_wdata << shamt;
      tx_shl  = tx << 1;
      rx_shl  = rx << 1;
      rx_shl[0] = spi_MISO;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_nx = LEAD;
               hcnt_nx  = HALF;
               bcnt_nx  = n_m1;
               tx_nx    = tx_load;
               rx_nx    = '0;
               sel_nx   = cmd_sel;
               csn_nx   = 1'b0;
               sclk_nx  = 1'b0;
               mosi_nx  = tx_load[DW-1];
               ready_nx = 1'b0;
               busy_nx  = 1'b1;
            end
         end
         LEAD: begin
            if (hcnt == '0) begin
               state_nx = SHIFT;
               hcnt_nx  = HALF;
               sclk_nx  = 1'b1;
               if (!LATE) rx_nx = rx_shl;
            end else begin
               hcnt_nx = hcnt - 1'b1;
            end
         end
         SHIFT: begin
            if (hcnt != '0) begin
               hcnt_nx = hcnt - 1'b1;
            end else if (spi_SCLK) begin
               // End of the high phase: SCLK falls, MOSI moves on unless this was the last bit.
               hcnt_nx = HALF;
               sclk_nx = 1'b0;
               if (LATE) rx_nx = rx_shl;
               if (bcnt != '0) begin
                  tx_nx   = tx_shl;
                  mosi_nx = tx_shl[DW-1];
               end
            end else if (bcnt == '0) begin
               state_nx = LAG;
               hcnt_nx  = HALF;
            end else begin
               // End of the low phase: start the next bit with a rising SCLK.
               hcnt_nx = HALF;
               bcnt_nx = bcnt - 1'b1;
               sclk_nx = 1'b1;
               if (!LATE) rx_nx = rx_shl;
            end
         end
         LAG: begin
            if (hcnt == '0) begin
               state_nx     = GAP;
               gcnt_nx      = GAP_LD;
               csn_nx       = 1'b1;
               sel_nx       = '0;
               mosi_nx      = 1'b0;
               rsp_valid_nx = 1'b1;
               rdata_nx     = rx;
            end else begin
               hcnt_nx = hcnt - 1'b1;
            end
         end
         GAP: begin
            if (gcnt == '0) begin
               state_nx = IDLE;
               ready_nx = 1'b1;
               busy_nx  = 1'b0;
            end else begin
               gcnt_nx = gcnt - 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tc_pl_spi_master.sv
// tb/tb_tc_pl_spi_master.sv - self-checking bench for tc_pl_spi_master
module tb_tc_pl_spi_master;

   localparam int DW_T  = 32;
   localparam int DIV_T = 2;
   localparam int GAP_T = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [7:0]        cmd_sel;
   logic [5:0]        cmd_len;
   logic [DW_T-1:0]   cmd_wdata;
   logic              rsp_valid;
   logic [DW_T-1:0]   rsp_rdata;
   logic              busy;
   logic [7:0]        chip_sel;
   logic              spi_CSN;
   logic              spi_SCLK;
   logic              spi_MOSI;
   logic              spi_MISO;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   logic [1:0]  miso_mode = 2'd0;
   logic        miso_reg  = 1'b0;
   logic [15:0] pat       = 16'h3C5A;
   logic        csn_q     = 1'b1;
   logic        sclk_q    = 1'b0;
   logic        pend      = 1'b0;
   int          idx       = 15;

   tc_pl_spi_master #(
      .AGP0_25 (8),
      .DW      (DW_T),
      .DIV     (DIV_T),
      .GAP_CYC (GAP_T)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_sel   (cmd_sel),
      .cmd_len   (cmd_len),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .chip_sel  (chip_sel),
      .spi_CSN   (spi_CSN),
      .spi_SCLK  (spi_SCLK),
      .spi_MOSI  (spi_MOSI),
      .spi_MISO  (spi_MISO)
   );

   always #5 clk = ~clk;

   // Mode 0 loops MOSI back; modes 1/2 emulate a slave shifting out pat.
   assign spi_MISO = (miso_mode == 2'd0) ? spi_MOSI : miso_reg;

   // Slave model: mode 1 updates on SCLK fall, mode 2 updates one clk after SCLK rises.
   always @(posedge clk) begin
      #1;
      if (miso_mode == 2'd2 && pend) begin
         if (idx >= 0) miso_reg = pat[idx];
         idx  = idx - 1;
         pend = 1'b0;
      end
      if (csn_q && !spi_CSN) begin
         pend = 1'b0;
         if (miso_mode == 2'd1) begin
            miso_reg = pat[15];
            idx      = 14;
         end else begin
            miso_reg = 1'b0;
            idx      = 15;
         end
      end else if (!spi_CSN) begin
         if (miso_mode == 2'd1 && sclk_q && !spi_SCLK && idx >= 0) begin
            miso_reg = pat[idx];
            idx      = idx - 1;
         end
         if (miso_mode == 2'd2 && !sclk_q && spi_SCLK) pend = 1'b1;
      end
      csn_q  = spi_CSN;
      sclk_q = spi_SCLK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   // Issue one command, observe the frame until cmd_ready returns, scoreboard the response.
   task automatic run_frame(input logic [7:0] sel, input logic [5:0] len, input logic [31:0] wdata,
                            input logic [31:0] exp, output int cyc, output int low, output int rises,
                            output logic [63:0] seq, output int rsps, output int sel_bad);
      int guard;
      logic prev;
      logic [31:0] exp_val;
      cyc = 0; low = 0; rises = 0; seq = '0; rsps = 0; sel_bad = 0;
      @(negedge clk);
      cmd_sel = sel; cmd_len = len; cmd_wdata = wdata; cmd_valid = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (!cmd_ready) begin
         errors++;
         $display("FAIL frame_accept_timeout got cmd_ready %b exp 1", cmd_ready);
      end
      exp_q.push_back(exp);
      prev = spi_SCLK;
      while (cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) cmd_valid = 1'b0;
         if (!spi_CSN) begin
            low++;
            if (chip_sel !== sel) sel_bad++;
         end
         if (spi_SCLK && !prev) begin
            rises++;
            seq = {seq[62:0], spi_MOSI};
         end
         prev = spi_SCLK;
         if (rsp_valid) begin
            rsps++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected got %h exp none", rsp_rdata);
            end else begin
               exp_val = exp_q.pop_front();
               if (rsp_rdata !== exp_val) begin
                  errors++;
                  $display("FAIL rsp_rdata got %h exp %h", rsp_rdata, exp_val);
               end
            end
         end
         if (cmd_ready) break;
      end
   endtask

   task automatic test_reset();
      logic [13:0] obs;
      int bad;
      rst = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_len = '0; cmd_wdata = '0;
      repeat (3) @(negedge clk);
      obs = {spi_CSN, spi_SCLK, spi_MOSI, chip_sel, cmd_ready, rsp_valid, busy};
      checks++;
      if (obs !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs got %b exp %b", obs, {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
      end
      checks++;
      if (rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h exp %h", rsp_rdata, 32'h0);
      end
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         obs = {spi_CSN, spi_SCLK, spi_MOSI, chip_sel, cmd_ready, rsp_valid, busy};
         if (obs !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL idle_outputs got %0d bad cycles exp 0", bad);
      end
   endtask

   task automatic test_basic(input logic [7:0] sel, input logic [5:0] len, input logic [31:0] wdata);
      int cyc, low, rises, rsps, sel_bad, n, exp_low;
      logic [63:0] seq;
      logic [31:0] exp;
      n       = (int'(len) + 1 > DW_T) ? DW_T : int'(len) + 1;
      exp     = (n == 32) ? wdata : (wdata & ((32'h1 << n) - 1));
      exp_low = 2 * DIV_T + 2 * DIV_T * n;
      miso_mode = 2'd0;
      run_frame(sel, len, wdata, exp, cyc, low, rises, seq, rsps, sel_bad);
      checks++;
      if (seq[31:0] !== exp) begin
         errors++;
         $display("FAIL basic_mosi_seq len %0d got %h exp %h", len, seq[31:0], exp);
      end
      checks++;
      if (rises != n) begin
         errors++;
         $display("FAIL basic_sclk_rises len %0d got %0d exp %0d", len, rises, n);
      end
      checks++;
      if (low != exp_low) begin
         errors++;
         $display("FAIL basic_csn_low len %0d got %0d exp %0d", len, low, exp_low);
      end
      checks++;
      if (cyc != 1 + exp_low + GAP_T) begin
         errors++;
         $display("FAIL basic_ready_return len %0d got %0d exp %0d", len, cyc, 1 + exp_low + GAP_T);
      end
      checks++;
      if (sel_bad != 0 || rsps != 1) begin
         errors++;
         $display("FAIL basic_sel_rsp got sel_bad %0d rsps %0d exp 0 1", sel_bad, rsps);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_rdata !== exp) begin
         errors++;
         $display("FAIL basic_rdata_hold got %h exp %h", rsp_rdata, exp);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, b_cyc, hi, rsps, overlap, guard;
      logic [31:0] exp_val;
      miso_mode = 2'd0;
      @(negedge clk);
      cmd_sel = 8'h10; cmd_len = 6'd7; cmd_wdata = 32'h0000_003C; cmd_valid = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      exp_q.push_back(32'h0000_003C);
      cyc = 0; b_cyc = -1; hi = 0; rsps = 0; overlap = 0;
      while (cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) cmd_wdata = 32'h0000_00C3;
         if (b_cyc >= 0 && cyc == b_cyc + 1) cmd_valid = 1'b0;
         if (cyc >= 2 && (b_cyc < 0 || cyc <= b_cyc + 1) && spi_CSN) hi++;
         if (cmd_ready && !spi_CSN) overlap++;
         if (rsp_valid) begin
            rsps++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_rsp_unexpected got %h exp none", rsp_rdata);
            end else begin
               exp_val = exp_q.pop_front();
               if (rsp_rdata !== exp_val) begin
                  errors++;
                  $display("FAIL b2b_rsp_rdata got %h exp %h", rsp_rdata, exp_val);
               end
            end
         end
         if (cmd_ready && b_cyc < 0) begin
            b_cyc = cyc;
            exp_q.push_back(32'h0000_00C3);
         end else if (cmd_ready && b_cyc >= 0) begin
            break;
         end
      end
      checks++;
      if (b_cyc != 1 + 2 * DIV_T + 16 * DIV_T + GAP_T) begin
         errors++;
         $display("FAIL b2b_second_accept got %0d exp %0d", b_cyc, 1 + 2 * DIV_T + 16 * DIV_T + GAP_T);
      end
      checks++;
      if (hi != GAP_T + 1) begin
         errors++;
         $display("FAIL b2b_csn_high got %0d exp %0d", hi, GAP_T + 1);
      end
      checks++;
      if (overlap != 0 || rsps != 2 || cyc != 2 * b_cyc) begin
         errors++;
         $display("FAIL b2b_overlap got overlap %0d rsps %0d end %0d exp 0 2 %0d", overlap, rsps, cyc, 2 * b_cyc);
      end
   endtask

   task automatic test_reset_mid();
      int guard, rises, bad_rsp, cyc, low, r2, rsps, sel_bad;
      logic prev;
      logic [13:0] obs;
      logic [63:0] seq;
      miso_mode = 2'd0;
      @(negedge clk);
      cmd_sel = 8'h20; cmd_len = 6'd15; cmd_wdata = 32'h0000_BEEF; cmd_valid = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      rises = 0; bad_rsp = 0; guard = 0; prev = spi_SCLK;
      while (rises < 11 && guard < 400) begin
         @(negedge clk);
         guard++;
         if (spi_SCLK && !prev) rises++;
         prev = spi_SCLK;
         if (rsp_valid) bad_rsp++;
      end
      checks++;
      if (spi_CSN !== 1'b0 || rises != 11) begin
         errors++;
         $display("FAIL midreset_in_frame got csn %b rises %0d exp 0 11", spi_CSN, rises);
      end
      rst = 1'b0;
      #1;
      obs = {spi_CSN, spi_SCLK, spi_MOSI, chip_sel, cmd_ready, rsp_valid, busy};
      checks++;
      if (obs !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0} || rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL midreset_outputs got %b rdata %h exp %b 0", obs, rsp_rdata, {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rsp_valid) bad_rsp++;
      end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid) bad_rsp++;
      end
      checks++;
      if (bad_rsp != 0) begin
         errors++;
         $display("FAIL midreset_no_rsp got %0d exp 0", bad_rsp);
      end
      run_frame(8'h20, 6'd15, 32'h0000_1234, 32'h0000_1234, cyc, low, r2, seq, rsps, sel_bad);
      checks++;
      if (r2 != 16 || low != 2 * DIV_T + 32 * DIV_T || seq[15:0] !== 16'h1234 || rsps != 1) begin
         errors++;
         $display("FAIL midreset_clean_frame got rises %0d low %0d seq %h rsps %0d exp 16 %0d 1234 1",
                  r2, low, seq[15:0], rsps, 2 * DIV_T + 32 * DIV_T);
      end
   endtask

   task automatic test_miso_pattern();
      int cyc, low, rises, rsps, sel_bad;
      logic [63:0] seq;
      miso_mode = 2'd1;
      run_frame(8'h02, 6'd15, 32'h0000_0000, 32'h0000_3C5A, cyc, low, rises, seq, rsps, sel_bad);
      checks++;
      if (rsps != 1 || rises != 16) begin
         errors++;
         $display("FAIL pattern_frame got rsps %0d rises %0d exp 1 16", rsps, rises);
      end
   endtask

   task automatic test_late_slave();
      int cyc, low, rises, rsps, sel_bad;
      logic [63:0] seq;
      logic [31:0] exp;
`ifdef TC_SPI_LATE_SAMPLE_EN
      exp = 32'h0000_3C5A;
`else
      exp = {17'h0, pat[15:1]};
`endif
      miso_mode = 2'd2;
      run_frame(8'h40, 6'd15, 32'h0000_0000, exp, cyc, low, rises, seq, rsps, sel_bad);
      checks++;
      if (rsps != 1 || low != 2 * DIV_T + 32 * DIV_T) begin
         errors++;
         $display("FAIL late_slave_frame got rsps %0d low %0d exp 1 %0d", rsps, low, 2 * DIV_T + 32 * DIV_T);
      end
      miso_mode = 2'd0;
   endtask

   initial begin
      test_reset();
      test_basic(8'h04, 6'd7, 32'h0000_00A5);
      test_basic(8'h81, 6'd0, 32'h0000_0001);
      test_basic(8'h01, 6'd11, 32'hFFFF_F5C3);
      test_basic(8'h08, 6'd63, 32'hDEAD_BEEF);
      test_back_to_back();
      test_reset_mid();
      test_miso_pattern();
      test_late_slave();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
